alu_seq_n: RTL and testbench

- Parametrised-width successor to the 8-bit pushbutton-loaded sequential ALU.
- Operands and opcode are captured on debounced-button rising edges: synchronised, single-trigger per press.
- Logic and arithmetic ops complete in one cycle; shifts run iteratively, one bit per clock, under a small FSM with busy/done.
- Adds SLL/SLT/SLTU, zero flag, invalid-opcode error; sits between the board I/O (switches/buttons) and the LED/display driver.

---
 rtl/alu_seq_n.sv | 229 ++++++++++++++++++++++
 tb/tb_alu_seq_n.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_n.sv
// Purpose: sequential ALU of width W; button-loaded operands, one-cycle logic/arith ops, bit-serial shifts.
// Latency: a press is acted on 2 edges after it is first sampled; results land then, shifts take n more edges.
// Backpressure: none; presses arriving while a shift is running are dropped, never queued.
//
// Ports:
//   clk, rst_n             clock (rising edge) and asynchronous active-low reset
//   buf_A, buf_B, buf_Op   switch data: operand A, operand B / shift amount, opcode (MIPS funct)
//   p_a, p_b, p_c          asynchronous level buttons: load A, load B, execute
//   buf_R, cout, ovf, zero registered result and flags
//   busy, done, err        shift in progress, completion pulse, last opcode invalid
module alu_seq_n #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] buf_A,
  input  logic [W-1:0] buf_B,
  input  logic [5:0]   buf_Op,
  input  logic         p_a,
  input  logic         p_b,
  input  logic         p_c,
  output logic [W-1:0] buf_R,
  output logic         cout,
  output logic         ovf,
  output logic         zero,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int SHW = $clog2(W);

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t state_q, state_d;

  // Button conditioning: bit 0 = A, 1 = B, 2 = execute.
  logic [2:0] btn_s1, btn_s2, btn_q, btn_edge;

  logic [W-1:0]   reg_a, reg_b, work;
  logic [SHW-1:0] cnt;
  logic [1:0]     sh_op;   // low opcode bits: 00 SLL, 10 SRL, 11 SRA

  logic ld_a, ld_b, exec_go, shift_step, shift_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_q  <= '0;
    end else begin
      btn_s1 <= {p_c, p_b, p_a};
      btn_s2 <= btn_s1;
      btn_q  <= btn_s2;
    end
  end

  assign btn_edge = btn_s2 & ~btn_q;

  // Single-cycle decode, always from the registered operands so a load on
  // the same edge as an execute does not affect that execute.
  logic [W:0]     add_full, sub_full;
  logic [SHW-1:0] sh_n;
  logic [W-1:0]   res;
  logic           res_c, res_o, op_valid, op_shift;

  assign add_full = {1'b0, reg_a} + {1'b0, reg_b};
  assign sub_full = {1'b0, reg_a} - {1'b0, reg_b};
  assign sh_n     = reg_b[SHW-1:0];

  always_comb begin
    res      = '0;
    res_c    = 1'b0;
    res_o    = 1'b0;
    op_valid = 1'b1;
    op_shift = 1'b0;
    case (buf_Op)
      OP_ADD: begin
        res   = add_full[W-1:0];
        res_c = add_full[W];
        res_o = (reg_a[W-1] == reg_b[W-1]) && (add_full[W-1] != reg_a[W-1]);
      end
      OP_SUB: begin
        res   = sub_full[W-1:0];
        res_c = sub_full[W];   // borrow
        res_o = (reg_a[W-1] != reg_b[W-1]) && (sub_full[W-1] != reg_a[W-1]);
      end
      OP_AND:  res = reg_a & reg_b;
      OP_OR:   res = reg_a | reg_b;
      OP_XOR:  res = reg_a ^ reg_b;
      OP_NOR:  res = ~(reg_a | reg_b);
      OP_SLT:  res = {{(W-1){1'b0}}, ($signed(reg_a) < $signed(reg_b))};
      OP_SLTU: res = {{(W-1){1'b0}}, (reg_a < reg_b)};
      OP_SLL, OP_SRL, OP_SRA: begin
        // A zero shift completes immediately with A passed through.
        res      = reg_a;
        op_shift = (sh_n != '0);
      end
      default: op_valid = 1'b0;
    endcase
  end

  // One-bit shift step of the working register.
  logic [W-1:0] work_nx;
  logic         sh_out;

  always_comb begin
    work_nx = work;
    sh_out  = 1'b0;
    case (sh_op)
      2'b00: begin
        work_nx = {work[W-2:0], 1'b0};
        sh_out  = work[W-1];
      end
      2'b11: begin
        work_nx = {work[W-1], work[W-1:1]};
        sh_out  = work[0];
      end
      default: begin
        work_nx = {1'b0, work[W-1:1]};
        sh_out  = work[0];
      end
    endcase
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (btn_edge[2] && op_valid && op_shift) state_d = S_SHIFT;
      S_SHIFT: if (cnt == SHW'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs and strobes.
  always_comb begin
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    exec_go    = 1'b0;
    shift_step = 1'b0;
    shift_last = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_IDLE: begin
        ld_a    = btn_edge[0];
        ld_b    = btn_edge[1];
        exec_go = btn_edge[2];
      end
      S_SHIFT: begin
        busy       = 1'b1;
        shift_step = 1'b1;
        shift_last = (cnt == SHW'(1));
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a <= '0;
      reg_b <= '0;
      work  <= '0;
      cnt   <= '0;
      sh_op <= '0;
      buf_R <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ld_a) reg_a <= buf_A;
      if (ld_b) reg_b <= buf_B;
      if (exec_go) begin
        if (!op_valid) begin
          // Result and flags hold; only err and done react.
          err  <= 1'b1;
          done <= 1'b1;
        end else begin
          err <= 1'b0;
          if (op_shift) begin
            work  <= reg_a;
            cnt   <= sh_n;
            sh_op <= buf_Op[1:0];
          end else begin
            buf_R <= res;
            cout  <= res_c;
            ovf   <= res_o;
            zero  <= (res == '0);
            done  <= 1'b1;
          end
        end
      end
      if (shift_step) begin
        work <= work_nx;
        cnt  <= cnt - SHW'(1);
        if (shift_last) begin
          buf_R <= work_nx;
          cout  <= sh_out;
          ovf   <= 1'b0;
          zero  <= (work_nx == '0);
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
module tb_alu_seq_n;

  localparam int MW = 8;

  localparam logic [5:0] OP_SLL  = 6'b000000;
  localparam logic [5:0] OP_SRL  = 6'b000010;
  localparam logic [5:0] OP_SRA  = 6'b000011;
  localparam logic [5:0] OP_ADD  = 6'b100000;
  localparam logic [5:0] OP_SUB  = 6'b100010;
  localparam logic [5:0] OP_AND  = 6'b100100;
  localparam logic [5:0] OP_OR   = 6'b100101;
  localparam logic [5:0] OP_XOR  = 6'b100110;
  localparam logic [5:0] OP_NOR  = 6'b100111;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTU = 6'b101011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  buf_A = '0, buf_B = '0;
  logic [15:0] buf_A16 = '0, buf_B16 = '0;
  logic [5:0]  buf_Op = '0;
  logic        p_a = 1'b0, p_b = 1'b0, p_c = 1'b0;

  logic [7:0]  r8;
  logic        c8, o8, z8, b8, d8, e8;
  logic [15:0] r16;
  logic        c16, o16, z16, b16, d16, e16;

  always #5 clk = ~clk;

  alu_seq_n #(.W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .buf_A(buf_A), .buf_B(buf_B), .buf_Op(buf_Op),
    .p_a(p_a), .p_b(p_b), .p_c(p_c),
    .buf_R(r8), .cout(c8), .ovf(o8), .zero(z8), .busy(b8), .done(d8), .err(e8)
  );

  alu_seq_n #(.W(16)) u16 (
    .clk(clk), .rst_n(rst_n), .buf_A(buf_A16), .buf_B(buf_B16), .buf_Op(buf_Op),
    .p_a(p_a), .p_b(p_b), .p_c(p_c),
    .buf_R(r16), .cout(c16), .ovf(o16), .zero(z16), .busy(b16), .done(d16), .err(e16)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the 8-bit instance ----------------
  int m_A, m_B, m_R, m_left, pend_R;
  bit m_c, m_o, m_z, m_done, m_err, pend_c;
  bit [2:0] ha, hb, hc;   // [0] = level at last edge, [1] one edge earlier, [2] two earlier

  function automatic int sg(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  task automatic model_reset();
    m_A = 0; m_B = 0; m_R = 0; m_left = 0; pend_R = 0;
    m_c = 0; m_o = 0; m_z = 0; m_done = 0; m_err = 0; pend_c = 0;
    ha = '0; hb = '0; hc = '0;
  endtask

  task automatic set_res(input int r, input bit c, input bit o);
    m_R = r; m_c = c; m_o = o; m_z = (r == 0); m_err = 0; m_done = 1;
  endtask

  task automatic model_exec(input logic [5:0] op, input int a, input int b);
    int n, s;
    n = b % MW;
    case (op)
      OP_ADD: begin
        s = sg(a) + sg(b);
        set_res((a + b) & 255, (a + b) > 255, (s > 127) || (s < -128));
      end
      OP_SUB: begin
        s = sg(a) - sg(b);
        set_res((a - b) & 255, a < b, (s > 127) || (s < -128));
      end
      OP_AND:  set_res(a & b, 0, 0);
      OP_OR:   set_res(a | b, 0, 0);
      OP_XOR:  set_res(a ^ b, 0, 0);
      OP_NOR:  set_res((~(a | b)) & 255, 0, 0);
      OP_SLT:  set_res((sg(a) < sg(b)) ? 1 : 0, 0, 0);
      OP_SLTU: set_res((a < b) ? 1 : 0, 0, 0);
      OP_SLL, OP_SRL, OP_SRA: begin
        if (n == 0) set_res(a, 0, 0);
        else begin
          m_left = n;
          m_err  = 0;
          if (op == OP_SLL) begin
            pend_R = (a << n) & 255;
            pend_c = ((a >> (MW - n)) & 1) != 0;
          end else if (op == OP_SRL) begin
            pend_R = a >> n;
            pend_c = ((a >> (n - 1)) & 1) != 0;
          end else begin
            pend_R = (sg(a) >>> n) & 255;
            pend_c = ((a >> (n - 1)) & 1) != 0;
          end
        end
      end
      default: begin
        m_err = 1; m_done = 1;
      end
    endcase
  endtask

  task automatic model_step();
    bit act_a, act_b, act_c;
    act_a = ha[1] && !ha[2];
    act_b = hb[1] && !hb[2];
    act_c = hc[1] && !hc[2];
    m_done = 0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_R = pend_R; m_c = pend_c; m_o = 0; m_z = (pend_R == 0); m_done = 1;
      end
    end else begin
      if (act_c) model_exec(buf_Op, m_A, m_B);
      if (act_a) m_A = int'(buf_A);
      if (act_b) m_B = int'(buf_B);
    end
    ha = {ha[1:0], p_a};
    hb = {hb[1:0], p_b};
    hc = {hc[1:0], p_c};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("buf_R", r8, m_R);
      chk("cout", c8, m_c);
      chk("ovf", o8, m_o);
      chk("zero", z8, m_z);
      chk("busy", b8, m_left > 0);
      chk("done", d8, m_done);
      chk("err", e8, m_err);
    end
  end

  // ---------------- directed helpers with literal expectations -------------
  int lat8, nd8, nb8, nb16;

  task automatic run_op(input logic [5:0] op, input int hold);
    @(negedge clk);
    buf_Op = op; p_c = 1'b1;
    lat8 = -1; nd8 = 0; nb8 = 0; nb16 = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == hold) p_c = 1'b0;
      if (d8) begin
        nd8++;
        if (lat8 < 0) lat8 = i;
      end
      if (b8)  nb8++;
      if (b16) nb16++;
    end
    p_c = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [5:0] op, input logic [7:0] er,
                           input bit ec, input bit eo, input int elat);
    run_op(op, 1);
    chk({name, "_R"}, r8, er);
    chk({name, "_cout"}, c8, ec);
    chk({name, "_ovf"}, o8, eo);
    chk({name, "_latency"}, lat8, elat);
    chk({name, "_done_count"}, nd8, 1);
  endtask

  task automatic load_a(input logic [7:0] v);
    @(negedge clk); buf_A = v; p_a = 1'b1;
    @(negedge clk); p_a = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_b(input logic [7:0] v);
    @(negedge clk); buf_B = v; p_b = 1'b1;
    @(negedge clk); p_b = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_R"}, r8, 0);
    chk({tag, "_cout"}, c8, 0);
    chk({tag, "_ovf"}, o8, 0);
    chk({tag, "_zero"}, z8, 0);
    chk({tag, "_busy"}, b8, 0);
    chk({tag, "_done"}, d8, 0);
    chk({tag, "_err"}, e8, 0);
  endtask

  logic [5:0] op_tab [11];
  initial op_tab = '{OP_SLL, OP_SRL, OP_SRA, OP_ADD, OP_SUB, OP_AND,
                     OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU};

  initial begin
    int cnt_done;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Execute with nothing loaded.
    expect_op("add_noload", OP_ADD, 8'h00, 0, 0, 3);
    chk("add_noload_zero", z8, 1);

    load_a(8'd20); load_b(8'd7);
    expect_op("add", OP_ADD, 8'd27, 0, 0, 3);
    expect_op("sub", OP_SUB, 8'd13, 0, 0, 3);
    expect_op("and", OP_AND, 8'd4, 0, 0, 3);
    expect_op("or",  OP_OR,  8'd23, 0, 0, 3);
    expect_op("xor", OP_XOR, 8'd19, 0, 0, 3);
    expect_op("nor", OP_NOR, 8'hE8, 0, 0, 3);

    load_a(8'hF4); load_b(8'd2);
    expect_op("sra", OP_SRA, 8'hFD, 0, 0, 5);
    chk("sra_busy_cycles", nb8, 2);
    expect_op("srl", OP_SRL, 8'h3D, 0, 0, 5);
    expect_op("sll", OP_SLL, 8'hD0, 1, 0, 5);
    expect_op("slt", OP_SLT, 8'h01, 0, 0, 3);
    expect_op("sltu", OP_SLTU, 8'h00, 0, 0, 3);

    load_a(8'd127); load_b(8'd1);
    expect_op("add_ovf", OP_ADD, 8'h80, 0, 1, 3);
    load_a(8'h80);
    expect_op("sub_ovf", OP_SUB, 8'h7F, 0, 1, 3);
    load_a(8'h01); load_b(8'h02);
    expect_op("sub_borrow", OP_SUB, 8'hFF, 1, 0, 3);
    load_a(8'hFF); load_b(8'h01);
    expect_op("add_carry", OP_ADD, 8'h00, 1, 0, 3);
    chk("add_carry_zero", z8, 1);

    // Long hold gives a single action.
    run_op(OP_OR, 6);
    chk("hold6_done_count", nd8, 1);
    chk("hold6_R", r8, 8'hFF);

    // Presses during a 7-step SRA are dropped.
    load_a(8'hF4); load_b(8'd7);
    @(negedge clk); buf_Op = OP_SRA; p_c = 1'b1;
    @(negedge clk); p_c = 1'b0;
    repeat (3) @(negedge clk);
    buf_A = 8'h11; buf_Op = OP_ADD; p_a = 1'b1; p_c = 1'b1;
    @(negedge clk); p_a = 1'b0; p_c = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (d8) cnt_done++;
    end
    chk("busy_press_done_count", cnt_done, 1);
    chk("sra7_R", r8, 8'hFF);
    chk("sra7_cout", c8, 1);
    expect_op("reg_a_kept", OP_ADD, 8'hFB, 0, 0, 3);

    // Load and execute on the same edge: old A is used.
    @(negedge clk); buf_A = 8'h10; buf_Op = OP_ADD; p_a = 1'b1; p_c = 1'b1;
    @(negedge clk); p_a = 1'b0; p_c = 1'b0;
    repeat (6) @(negedge clk);
    chk("same_edge_old_a", r8, 8'hFB);
    expect_op("same_edge_new_a", OP_ADD, 8'h17, 0, 0, 3);

    // Invalid opcode.
    run_op(6'b111111, 1);
    chk("inv_err", e8, 1);
    chk("inv_R_held", r8, 8'h17);
    chk("inv_latency", lat8, 3);
    expect_op("err_clear", OP_ADD, 8'h17, 0, 0, 3);
    chk("err_cleared", e8, 0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      buf_A = 8'($urandom);
      buf_B = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        buf_Op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 10)];
      if ($urandom_range(0, 5) == 0) p_a = ~p_a;
      if ($urandom_range(0, 5) == 0) p_b = ~p_b;
      if ($urandom_range(0, 4) == 0) p_c = ~p_c;
    end
    @(negedge clk); p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;
    repeat (30) @(negedge clk);

    // Reset in the middle of a shift.
    load_a(8'hF4); load_b(8'd7);
    @(negedge clk); buf_Op = OP_SRA; p_c = 1'b1;
    @(negedge clk); p_c = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", b8, 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("midrun_reset");
    @(negedge clk); rst_n = 1'b1;
    expect_op("post_reset_add", OP_ADD, 8'h00, 0, 0, 3);
    chk("post_reset_zero", z8, 1);

    // Wide instance: 15-step arithmetic shift.
    buf_A16 = 16'h8000; buf_B16 = 16'd15;
    load_a(8'h01); load_b(8'h03);
    run_op(OP_SRA, 1);
    chk("w16_R", r16, 16'hFFFF);
    chk("w16_busy_cycles", nb16, 15);
    chk("w16_cout", c16, 0);
    chk("w16_ovf", o16, 0);
    chk("w16_zero", z16, 0);
    chk("w16_err", e16, 0);
    chk("w16_done_seen", d16, 0);
    chk("w8_sra3_R", r8, 8'h00);
    chk("w8_sra3_latency", lat8, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
